sha_msg_padder: RTL



---
 rtl/sha_msg_padder_if.sv | 32 +++
 rtl/sha_msg_padder.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/sha_msg_padder_if.sv
`default_nettype none
// ============================================================================
// Module      : sha_msg_padder_if
// Description : Handshake bundle for the SHA-256 message padder.
//               Word side   : in_valid / in_ready / in_data / in_last / in_bytes
//               Block side  : blk_valid / blk_ready / blk_data / blk_last
//               master : word source plus block consumer (drives in_*, blk_ready)
//               slave  : the padder (drives in_ready, blk_*)
// Revision    : 1.0 - initial release
// ============================================================================
interface sha_msg_padder_if;
    logic         in_valid;
    logic [63:0]  in_data;
    logic         in_last;
    logic [3:0]   in_bytes;
    logic         in_ready;
    logic         blk_valid;
    logic [511:0] blk_data;
    logic         blk_last;
    logic         blk_ready;

    modport master (
        output in_valid, in_data, in_last, in_bytes, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_last
    );

    modport slave (
        input  in_valid, in_data, in_last, in_bytes, blk_ready,
        output in_ready, blk_valid, blk_data, blk_last
    );
endinterface
`default_nettype wire

// File: rtl/sha_msg_padder.sv
`default_nettype none
// ============================================================================
// Module      : sha_msg_padder
// Description : Streaming SHA-256 message padder. Packs 64-bit big-endian
//               message words into 512-bit blocks, appends the 0x80 marker,
//               zero fill and the 64-bit message bit length.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               bus    - sha_msg_padder_if.slave (word input, block output)
// Revision    : 1.0 - initial release
// ============================================================================
module sha_msg_padder (
    input  wire              clk,
    input  wire              rst_n,
    sha_msg_padder_if.slave  bus
);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_PAD  = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    localparam logic [63:0] c_MARK_WORD = 64'h8000_0000_0000_0000;

    state_t           r_state;
    logic [0:7][63:0] r_buf;       // word 0 is the most significant slice
    logic [2:0]       r_p;
    logic [63:0]      r_len;
    logic             r_pend80;    // 0x80 still owed (last word was full)
    logic             r_padding;   // message ended, block(s) still to close
    logic             r_blk_valid;
    logic             r_blk_last;

    logic [3:0]       w_nb;
    logic [63:0]      w_last_word;
    logic [63:0]      w_pad_word;
    logic [63:0]      w_bits;
    logic             w_accept;

    always_comb begin
        w_nb        = (bus.in_bytes > 4'd8) ? 4'd8 : bus.in_bytes;
        // Keep the leading nb bytes, drop the 0x80 marker right behind them.
        w_last_word = '0;
        for (int b = 0; b < 8; b++) begin
            if (4'(b) < w_nb)
                w_last_word[63-8*b -: 8] = bus.in_data[63-8*b -: 8];
            else if (4'(b) == w_nb)
                w_last_word[63-8*b -: 8] = 8'h80;
        end
        w_pad_word  = r_pend80 ? c_MARK_WORD : 64'd0;
        w_bits      = {57'd0, w_nb, 3'd0};
        w_accept    = bus.in_valid && (r_state == S_FILL);
    end

    assign bus.in_ready  = (r_state == S_FILL);
    assign bus.blk_valid = r_blk_valid;
    assign bus.blk_last  = r_blk_last;
    assign bus.blk_data  = r_buf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FILL;
            r_buf       <= '0;
            r_p         <= 3'd0;
            r_len       <= 64'd0;
            r_pend80    <= 1'b0;
            r_padding   <= 1'b0;
            r_blk_valid <= 1'b0;
            r_blk_last  <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        if (!bus.in_last) begin
                            r_buf[r_p] <= bus.in_data;
                            r_len      <= r_len + 64'd64;
                        end else begin
                            r_buf[r_p] <= w_last_word;
                            r_len      <= r_len + w_bits;
                            r_pend80   <= (w_nb == 4'd8);
                            r_padding  <= 1'b1;
                            r_state    <= S_PAD;
                        end
                        // A full buffer always goes out as a non-final block;
                        // a message ending here still needs room for L.
                        if (r_p == 3'd7) begin
                            r_blk_valid <= 1'b1;
                            r_blk_last  <= 1'b0;
                            r_p         <= 3'd0;
                            r_state     <= S_EMIT;
                        end else begin
                            r_p <= r_p + 3'd1;
                        end
                    end
                end

                S_PAD: begin
                    if ((r_p == 3'd7) && !r_pend80) begin
                        r_buf[7]    <= r_len;
                        r_blk_valid <= 1'b1;
                        r_blk_last  <= 1'b1;
                        r_state     <= S_EMIT;
                    end else begin
                        r_buf[r_p] <= w_pad_word;
                        r_pend80   <= 1'b0;
                        if (r_p == 3'd7) begin
                            r_blk_valid <= 1'b1;
                            r_blk_last  <= 1'b0;
                            r_p         <= 3'd0;
                            r_state     <= S_EMIT;
                        end else begin
                            r_p <= r_p + 3'd1;
                        end
                    end
                end

                S_EMIT: begin
                    if (r_blk_valid && bus.blk_ready) begin
                        r_blk_valid <= 1'b0;
                        if (r_blk_last) begin
                            r_blk_last <= 1'b0;
                            r_padding  <= 1'b0;
                            r_len      <= 64'd0;
                            r_p        <= 3'd0;
                            r_state    <= S_FILL;
                        end else if (r_padding) begin
                            r_state <= S_PAD;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end
                end

                default: r_state <= S_FILL;
            endcase
        end
    end

endmodule
`default_nettype wire
